usr_serial_tx: RTL
==================

// Module: usr_serial_tx
// PURPOSE
//  Parallel-in, serial-out word transmitter; the sending end of a serial shift chain.
//  Accepts one WIDTH-bit word per load handshake and emits it one bit per accepted beat.
//  Beats go to a downstream universal shift register that shifts in on SVALID&SREADY.
//  Bit numbering is big-endian: bit 0 is MSB. DIR selects which end leaves first.
// PARAMETERS
//  WIDTH  36  word width in bits; legal range 2..64
// PORTS
//  CLK         in   1      single clock; all state changes on rising edge
//  RESET_N     in   1      asynchronous, active-low reset
//  LOAD_VALID  in   1      parallel word offered
//  LOAD_READY  out  1      transmitter can accept a word this cycle
//  D           in   WIDTH  [0:WIDTH-1] parallel word
//  DIR         in   1      0: bit 0 first (rx shifts toward bit 0); 1: bit WIDTH-1 first
//  ABORT       in   1      synchronous: drop the word in flight
//  SOUT        out  1      current serial bit; valid only while SVALID=1
//  SVALID      out  1      SOUT holds a beat
//  SREADY      in   1      receiver consumes the beat this cycle
//  SLAST       out  1      current beat is the final beat of the word
//  BUSY        out  1      a word is in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (RESET_N=0, asynchronous): state IDLE; shift reg and counter cleared; SOUT=0.
//    SVALID=0, SLAST=0, BUSY=0. LOAD_READY is forced 0 while RESET_N=0.
//  - States: IDLE, SHIFT, PAR. PAR exists only with the option below.
//  - Load: handshake completes on a rising edge with LOAD_VALID & LOAD_READY & !ABORT.
//    Captures D and DIR, sets the beat counter to WIDTH-1, enters SHIFT.
//    First beat appears the next cycle; load-to-first-beat latency is 1 clock.
//  - SHIFT: SVALID=1. SOUT = first-end bit of the shift reg (bit 0 if DIR=0, else bit WIDTH-1).
//    A beat advances only on SVALID & SREADY. The reg shifts toward the leaving end.
//    The counter decrements once per advanced beat.
//    SREADY=0 stalls: SOUT, SLAST and the counter hold indefinitely.
//  - Final data beat (counter=0):
//    - With SREADY=1 and no parity: go IDLE.
//    - In the same cycle, LOAD_READY=1 (combinational on SREADY). A concurrent load
//      goes straight back to SHIFT: back-to-back words with no idle gap.
//  - LOAD_READY = RESET_N & !ABORT & (IDLE | final-beat-consumed-this-cycle).
//    D and DIR are ignored at all other times; a word in flight is never altered.
//  - ABORT=1: next state IDLE from any state; shift reg contents discarded.
//    SVALID=0 from the next cycle. A beat consumed in the ABORT cycle still counts
//    downstream. ABORT beats LOAD_VALID in the same cycle, so no load occurs.
//  - Counter width $clog2(WIDTH); no wrap: the counter is reloaded only on load.
//  - SLAST=1 exactly on the final beat of the word. BUSY=1 in SHIFT and PAR.
// CONFIGURATION
//  USR_TX_PARITY_EN defined:
//   - One extra beat follows the data: state PAR, SOUT = odd parity over the captured word.
//   - The XOR of all data bits and the parity bit is 1.
//   - SLAST moves to the parity beat. Back-to-back load and the IDLE return occur on
//     the parity beat. Total WIDTH+1 beats.
//  USR_TX_PARITY_EN undefined:
//   - No PAR state; WIDTH beats; SLAST on the last data bit.
// TESTING (WIDTH=36 unless noted)
//  1. D=36'o123456701234, DIR=0, SREADY=1 -> 36 consecutive beats, bit 0 first.
//     SLAST only on beat 36. A USR chain shifting toward bit 0 reconstructs D exactly.
//  2. Same D, DIR=1, and SREADY=0 for 3 cycles at beat 6 -> bit 35 first.
//     Beat 6 SOUT held 4 cycles with SVALID=1. Total 39 cycles, data intact.
//  3. Two words 36'o777777000000 then 36'o000000777777, LOAD_VALID held -> 72 contiguous
//     beats. LOAD_READY pulses only on the final-beat cycle and SVALID never drops.
//  4. ABORT with LOAD_VALID=1 at beat 10 -> next cycle SVALID=0, BUSY=0.
//     The load in the ABORT cycle is not accepted. The following cycle accepts a new word.
//  5. RESET_N low mid-word at beat 20 -> SVALID, BUSY, SLAST, LOAD_READY go 0 immediately.
//     After release, state is IDLE and LOAD_READY=1.
//  6. USR_TX_PARITY_EN, D=36'o1 -> beat 37 SOUT=0 with SLAST. D=36'o0 -> beat 37 SOUT=1.
//     Without the macro, SLAST falls on beat 36.

Source files
------------

// File: rtl/usr_serial_tx.sv
// rtl/usr_serial_tx.sv - parallel-in, serial-out word transmitter
//
// Purpose: accepts one WIDTH-bit word per load handshake and emits it one bit
// per accepted beat (SVALID & SREADY) toward a downstream shift register.
// Bit numbering is big-endian (D[0] is the MSB); DIR picks the leaving end.
//
// Optional feature macro: USR_TX_PARITY_EN
//   defined   : an odd-parity beat follows the data (WIDTH+1 beats per word)
//   undefined : WIDTH beats per word, SLAST on the last data bit
//
// Ports:
//   CLK         in   clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   LOAD_VALID  in   parallel word offered
//   LOAD_READY  out  word can be accepted this cycle
//   D           in   [0:WIDTH-1] parallel word
//   DIR         in   0: D[0] first, 1: D[WIDTH-1] first
//   ABORT       in   synchronous drop of the word in flight
//   SOUT        out  current serial bit (meaningful while SVALID=1)
//   SVALID      out  SOUT holds a beat
//   SREADY      in   receiver consumes the beat this cycle
//   SLAST       out  current beat is the final beat of the word
//   BUSY        out  a word is in flight

module usr_serial_tx #(
  parameter int WIDTH = 36
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [0:WIDTH-1] D,
  input  logic             DIR,
  input  logic             ABORT,
  output logic             SOUT,
  output logic             SVALID,
  input  logic             SREADY,
  output logic             SLAST,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef USR_TX_PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]       state;
  logic [0:WIDTH-1] sr;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic             last_data;
  logic             word_done;
  logic             load;
  logic             first_bit;

`ifdef USR_TX_PARITY_EN
  logic             par_q;
`endif

  assign last_data = (state == SHIFT) && (cnt == '0);
  assign first_bit = dir_q ? sr[WIDTH-1] : sr[0];

`ifdef USR_TX_PARITY_EN
  // The parity beat is the last beat of the word.
  assign word_done = (state == PAR) && SREADY;
  assign SLAST     = (state == PAR);
  assign SOUT      = (state == PAR) ? par_q : ((state == SHIFT) ? first_bit : 1'b0);
`else
  assign word_done = last_data && SREADY;
  assign SLAST     = last_data;
  assign SOUT      = (state == SHIFT) ? first_bit : 1'b0;
`endif

  // Ready is combinational on SREADY during the final beat so a held
  // LOAD_VALID chains words with no idle gap.
  assign LOAD_READY = RESET_N && !ABORT && ((state == IDLE) || word_done);
  assign load       = LOAD_VALID && LOAD_READY;
  assign SVALID     = (state != IDLE);
  assign BUSY       = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
`ifdef USR_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (ABORT) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else if (load) begin
      state <= SHIFT;
      sr    <= D;
      dir_q <= DIR;
      cnt   <= CW'(WIDTH - 1);
`ifdef USR_TX_PARITY_EN
      // Odd parity: XOR over data plus parity bit equals 1.
      par_q <= ~^D;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (SREADY) begin
            if (cnt == '0) begin
`ifdef USR_TX_PARITY_EN
              state <= PAR;
`else
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt - CW'(1);
              // Move the next bit onto the leaving end.
              if (dir_q) sr <= {1'b0, sr[0:WIDTH-2]};
              else       sr <= {sr[1:WIDTH-1], 1'b0};
            end
          end
        end
`ifdef USR_TX_PARITY_EN
        PAR: begin
          if (SREADY) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
